// File: rtl/mult_sched_pkg.sv
// Shared state encoding and constants for the multiplier scheduler and its arbiter.
package mult_sched_pkg;

   localparam int DEFAULT_DATA_W = 16;
   localparam int GAP_CYCLES     = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_GAP   = 2'd3
   } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational priority scan upward from a registered pointer,
// pointer moves one past the winner whenever the caller accepts the grant.
module rr_arbiter #(
   parameter int N_REQ = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req,
   input  logic                       advance,
   output logic [N_REQ-1:0]           grant_oh,
   output logic [$clog2(N_REQ)-1:0]   grant_idx,
   output logic                       valid
);

   localparam int IDX_W = $clog2(N_REQ);

   logic [IDX_W-1:0] ptr_q, ptr_d;
   int               idx;

   always_comb begin
      grant_oh  = '0;
      grant_idx = '0;
      valid     = 1'b0;
      idx       = 0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = (int'(ptr_q) + i) % N_REQ;
         if (!valid && req[IDX_W'(idx)]) begin
            valid                  = 1'b1;
            grant_idx              = IDX_W'(idx);
            grant_oh[IDX_W'(idx)]  = 1'b1;
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (advance && valid) begin
         ptr_d = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/multiplier_scheduler.sv
// Shares one multiplier core among N_REQ requesters (IDLE/ISSUE/WAIT/GAP sequence).
// Optional WAIT timeout with ERR strobe is enabled by defining MULT_SCHED_TIMEOUT_EN.
module multiplier_scheduler
   import mult_sched_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int DATA_W  = DEFAULT_DATA_W,
   parameter int TIMEOUT = 32
) (
   input  logic                    M_CLK,
   input  logic                    RESET,
   input  logic [N_REQ-1:0]        REQ,
   input  logic [N_REQ*DATA_W-1:0] OP_A,
   input  logic [N_REQ*DATA_W-1:0] OP_B,
   output logic [N_REQ-1:0]        GRANT,
   output logic [N_REQ-1:0]        DONE,
   output logic [DATA_W-1:0]       RESULT,
   output logic                    BUSY,
   output logic                    ERR,
   output logic                    MUL_TRIGGER,
   output logic [DATA_W-1:0]       MUL_DATA_1,
   output logic [DATA_W-1:0]       MUL_DATA_2,
   input  logic [DATA_W-1:0]       MUL_DATA_OUT,
   input  logic                    MUL_DATA_READY
);

   localparam int IDX_W = $clog2(N_REQ);

   if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_bad_params
      $error("multiplier_scheduler: N_REQ must be 2..8 and TIMEOUT >= 1");
   end

   state_t            state_q, state_d;
   logic [N_REQ-1:0]  grant_q, grant_d;
   logic [N_REQ-1:0]  done_q, done_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic [DATA_W-1:0] data_1_q, data_1_d;
   logic [DATA_W-1:0] data_2_q, data_2_d;
   logic              trigger_q, trigger_d;
   logic [1:0]        gap_cnt_q, gap_cnt_d;

   logic [N_REQ-1:0]  arb_grant;
   logic [IDX_W-1:0]  arb_idx;
   logic              arb_valid;
   logic              arb_advance;

`ifdef MULT_SCHED_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
   logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic              err_q, err_d;
`endif

   rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .clk       (M_CLK),
      .rst       (RESET),
      .req       (REQ),
      .advance   (arb_advance),
      .grant_oh  (arb_grant),
      .grant_idx (arb_idx),
      .valid     (arb_valid)
   );

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      done_d      = '0;
      result_d    = result_q;
      data_1_d    = data_1_q;
      data_2_d    = data_2_q;
      trigger_d   = trigger_q;
      gap_cnt_d   = gap_cnt_q;
      arb_advance = 1'b0;
`ifdef MULT_SCHED_TIMEOUT_EN
      wait_cnt_d  = wait_cnt_q;
      err_d       = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (arb_valid) begin
               arb_advance = 1'b1;
               grant_d     = arb_grant;
               data_1_d    = OP_A[arb_idx*DATA_W +: DATA_W];
               data_2_d    = OP_B[arb_idx*DATA_W +: DATA_W];
               state_d     = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            trigger_d = 1'b1;
            state_d   = ST_WAIT;
`ifdef MULT_SCHED_TIMEOUT_EN
            wait_cnt_d = '0;
`endif
         end
         ST_WAIT: begin
            if (MUL_DATA_READY) begin
               result_d  = MUL_DATA_OUT;
               done_d    = grant_q;
               trigger_d = 1'b0;
               grant_d   = '0;
               gap_cnt_d = '0;
               state_d   = ST_GAP;
            end
`ifdef MULT_SCHED_TIMEOUT_EN
            else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
               result_d  = '0;
               done_d    = grant_q;
               err_d     = 1'b1;
               trigger_d = 1'b0;
               grant_d   = '0;
               gap_cnt_d = '0;
               state_d   = ST_GAP;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
`endif
         end
         ST_GAP: begin
            // Holding TRIGGER low here lets the core's edge detector see a falling level.
            if (gap_cnt_q == 2'(GAP_CYCLES - 1)) begin
               state_d = ST_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + 2'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge M_CLK) begin
      if (RESET) begin
         state_q   <= ST_IDLE;
         grant_q   <= '0;
         done_q    <= '0;
         result_q  <= '0;
         data_1_q  <= '0;
         data_2_q  <= '0;
         trigger_q <= 1'b0;
         gap_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         done_q    <= done_d;
         result_q  <= result_d;
         data_1_q  <= data_1_d;
         data_2_q  <= data_2_d;
         trigger_q <= trigger_d;
         gap_cnt_q <= gap_cnt_d;
      end
   end

`ifdef MULT_SCHED_TIMEOUT_EN
   always_ff @(posedge M_CLK) begin
      if (RESET) begin
         wait_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         err_q      <= err_d;
      end
   end
   assign ERR = err_q;
`else
   assign ERR = 1'b0;
`endif

   assign GRANT       = grant_q;
   assign DONE        = done_q;
   assign RESULT      = result_q;
   assign BUSY        = (state_q != ST_IDLE);
   assign MUL_TRIGGER = trigger_q;
   assign MUL_DATA_1  = data_1_q;
   assign MUL_DATA_2  = data_2_q;

endmodule

// File: tb/tb_multiplier_scheduler.sv
// Directed bench for multiplier_scheduler; the bench plays the multiplier core by hand.
module tb_multiplier_scheduler;

   localparam int N = 4;
   localparam int W = 16;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req;
   logic [N*W-1:0] op_a, op_b;
   logic [N-1:0]   grant, done;
   logic [W-1:0]   result;
   logic           busy, err, trig;
   logic [W-1:0]   d1, d2;
   logic [W-1:0]   dout;
   logic           rdy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   multiplier_scheduler #(.N_REQ(N), .DATA_W(W), .TIMEOUT(32)) dut (
      .M_CLK          (clk),
      .RESET          (rst),
      .REQ            (req),
      .OP_A           (op_a),
      .OP_B           (op_b),
      .GRANT          (grant),
      .DONE           (done),
      .RESULT         (result),
      .BUSY           (busy),
      .ERR            (err),
      .MUL_TRIGGER    (trig),
      .MUL_DATA_1     (d1),
      .MUL_DATA_2     (d2),
      .MUL_DATA_OUT   (dout),
      .MUL_DATA_READY (rdy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Bench core: signed product scaled down by 8.
   function automatic logic [15:0] core_model(input logic signed [15:0] a, input logic signed [15:0] b);
      logic signed [31:0] p;
      p = a * b;
      return p[18:3];
   endfunction

   task automatic serve(input int idx, input int lat, input bit drop);
      logic [15:0] a, b, prod;
      a    = op_a[idx*W +: W];
      b    = op_b[idx*W +: W];
      prod = core_model(a, b);
      tick;
      chk("grant", {28'd0, grant}, 32'(1 << idx));
      chk("data1", {16'd0, d1}, {16'd0, a});
      chk("data2", {16'd0, d2}, {16'd0, b});
      chk("trig_issue", {31'd0, trig}, 32'd0);
      tick;
      chk("trig_rise", {31'd0, trig}, 32'd1);
      chk("busy_wait", {31'd0, busy}, 32'd1);
      if (drop) req[idx] = 1'b0;
      repeat (lat) tick;
      chk("no_early_done", {28'd0, done}, 32'd0);
      dout = prod;
      rdy  = 1'b1;
      tick;
      rdy  = 1'b0;
      chk("done", {28'd0, done}, 32'(1 << idx));
      chk("result", {16'd0, result}, {16'd0, prod});
      chk("trig_fall", {31'd0, trig}, 32'd0);
      chk("grant_clr", {28'd0, grant}, 32'd0);
      tick;
      chk("done_once", {28'd0, done}, 32'd0);
      chk("gap_busy", {31'd0, busy}, 32'd1);
      chk("gap_trig", {31'd0, trig}, 32'd0);
      tick;
      chk("back_idle", {31'd0, busy}, 32'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_grant"}, {28'd0, grant}, 32'd0);
      chk({tag, "_done"}, {28'd0, done}, 32'd0);
      chk({tag, "_result"}, {16'd0, result}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_err"}, {31'd0, err}, 32'd0);
      chk({tag, "_trig"}, {31'd0, trig}, 32'd0);
      chk({tag, "_d1"}, {16'd0, d1}, 32'd0);
      chk({tag, "_d2"}, {16'd0, d2}, 32'd0);
   endtask

   initial begin
      logic [15:0] last_res;
      rst  = 1'b1;
      req  = '0;
      rdy  = 1'b0;
      dout = '0;
      op_a = '0;
      op_b = '0;
      op_a[0*W +: W] = 16'd100;    op_b[0*W +: W] = 16'd200;
      op_a[1*W +: W] = -16'sd300;  op_b[1*W +: W] = 16'd7;
      op_a[2*W +: W] = 16'd1234;   op_b[2*W +: W] = -16'sd56;
      op_a[3*W +: W] = 16'd32767;  op_b[3*W +: W] = 16'd2;
      tick;
      tick;
      chk_all_zero("reset");
      rst = 1'b0;

      // Single request from requester 0
      req = 4'b0001;
      serve(0, 3, 1'b0);
      chk("result_hand", {16'd0, result}, 32'h0000_09C4);
      req = '0;
      tick;

      // All four requesting: order 0,1,2,3,0 from a fresh pointer
      rst = 1'b1;
      tick;
      rst = 1'b0;
      req = 4'b1111;
      serve(0, 1, 1'b0);
      serve(1, 0, 1'b0);
      serve(2, 4, 1'b0);
      serve(3, 2, 1'b0);
      chk("result_sat_in", {16'd0, result}, 32'h0000_1FFF);
      serve(0, 1, 1'b0);
      req = '0;

      // Requester 2 drops REQ while waiting
      req = 4'b0100;
      serve(2, 3, 1'b1);
      req = '0;
      tick;
      tick;
      tick;
      chk("drop_no_regrant", {28'd0, grant}, 32'd0);
      chk("drop_idle", {31'd0, busy}, 32'd0);

      // Reset in WAIT, then a stale ready pulse
      req = 4'b0010;
      tick;
      tick;
      tick;
      rst = 1'b1;
      req = '0;
      tick;
      rst = 1'b0;
      chk_all_zero("midreset");
      dout = 16'h1234;
      rdy  = 1'b1;
      tick;
      rdy  = 1'b0;
      chk("stale_result", {16'd0, result}, 32'd0);
      chk("stale_done", {28'd0, done}, 32'd0);
      chk("stale_busy", {31'd0, busy}, 32'd0);
      req = 4'b1000;
      serve(3, 2, 1'b0);
      req = '0;
      last_res = core_model(op_a[3*W +: W], op_b[3*W +: W]);

      // Ready pulse while idle is ignored
      dout = 16'h7777;
      rdy  = 1'b1;
      tick;
      rdy  = 1'b0;
      chk("idle_rdy_result", {16'd0, result}, {16'd0, last_res});
      chk("idle_rdy_done", {28'd0, done}, 32'd0);
      tick;
      chk("idle_rdy_done2", {28'd0, done}, 32'd0);

      // Core that does not answer
      req = 4'b0001;
      tick;
      tick;
      chk("nr_trig", {31'd0, trig}, 32'd1);
`ifdef MULT_SCHED_TIMEOUT_EN
      repeat (31) tick;
      chk("to_err_early", {31'd0, err}, 32'd0);
      tick;
      req = '0;
      chk("to_err", {31'd0, err}, 32'd1);
      chk("to_done", {28'd0, done}, 32'd1);
      chk("to_result", {16'd0, result}, 32'd0);
      chk("to_trig", {31'd0, trig}, 32'd0);
      tick;
      chk("to_err_once", {31'd0, err}, 32'd0);
      chk("to_done_once", {28'd0, done}, 32'd0);
      tick;
      chk("to_idle", {31'd0, busy}, 32'd0);
`else
      repeat (40) tick;
      chk("nt_err", {31'd0, err}, 32'd0);
      chk("nt_busy", {31'd0, busy}, 32'd1);
      chk("nt_done", {28'd0, done}, 32'd0);
      chk("nt_trig", {31'd0, trig}, 32'd1);
      dout = 16'h0042;
      rdy  = 1'b1;
      tick;
      rdy  = 1'b0;
      req  = '0;
      chk("nt_late_done", {28'd0, done}, 32'd1);
      chk("nt_late_result", {16'd0, result}, 32'h0000_0042);
      tick;
      tick;
      chk("nt_idle", {31'd0, busy}, 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
